// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing plus
// HI/LO multiply-divide issue with a busy counter that stalls MDU-class ops.
module mc_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWE,
  output logic       IRWE,
  output logic [2:0] NPCOp,
  output logic       immExtOp,
  output logic [3:0] ALUOp,
  output logic       BSel,
  output logic       DMWE,
  output logic       RFWE,
  output logic [1:0] WRSel,
  output logic [1:0] RFWDSel,
  output logic       HILOSel,
  output logic       MDUStart,
  output logic [2:0] MDUOp,
  output logic       HILOWE,
  output logic       MDUBusy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic add, sub, slt, jr;
    logic mult, multu, div, divu;
    logic mthi, mtlo, mfhi, mflo;
    logic ori, lui, lw, sw, beq, j, jal;
  } dec_t;

  state_t           cur, nxt;
  dec_t             d;
  logic [CNT_W-1:0] busy_cnt;
  logic             alu_r, mdu_go, mdu_mt, mdu_mf, mdu_cls, legal;

  always_comb begin
    d = '0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: d.add   = 1'b1;
        6'h22: d.sub   = 1'b1;
        6'h2a: d.slt   = 1'b1;
        6'h08: d.jr    = 1'b1;
        6'h18: d.mult  = 1'b1;
        6'h19: d.multu = 1'b1;
        6'h1a: d.div   = 1'b1;
        6'h1b: d.divu  = 1'b1;
        6'h11: d.mthi  = 1'b1;
        6'h13: d.mtlo  = 1'b1;
        6'h10: d.mfhi  = 1'b1;
        6'h12: d.mflo  = 1'b1;
        default: ;
      endcase
    end else begin
      case (opcode)
        6'h0d: d.ori = 1'b1;
        6'h0f: d.lui = 1'b1;
        6'h23: d.lw  = 1'b1;
        6'h2b: d.sw  = 1'b1;
        6'h04: d.beq = 1'b1;
        6'h02: d.j   = 1'b1;
        6'h03: d.jal = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_r   = d.add | d.sub | d.slt;
  assign mdu_go  = d.mult | d.multu | d.div | d.divu;
  assign mdu_mt  = d.mthi | d.mtlo;
  assign mdu_mf  = d.mfhi | d.mflo;
  assign mdu_cls = mdu_go | mdu_mt | mdu_mf;
  assign legal   = |d;
  assign MDUBusy = (busy_cnt != '0);
  assign state   = cur;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // MDUStart is already gated by reset, so a load never races an abort.
  always_ff @(posedge clk) begin
    if (reset)
      busy_cnt <= '0;
    else if (MDUStart)
      busy_cnt <= (d.mult | d.multu) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - CNT_W'(1);
  end

  always_comb begin
    nxt      = cur;
    PCWE     = 1'b0;
    IRWE     = 1'b0;
    NPCOp    = 3'd0;
    immExtOp = 1'b0;
    ALUOp    = 4'd0;
    BSel     = 1'b0;
    DMWE     = 1'b0;
    RFWE     = 1'b0;
    WRSel    = 2'd0;
    RFWDSel  = 2'd0;
    HILOSel  = 1'b0;
    MDUStart = 1'b0;
    MDUOp    = 3'd0;
    HILOWE   = 1'b0;
    case (cur)
      FETCH: begin
        IRWE = 1'b1;
        PCWE = 1'b1;
        nxt  = DECODE;
      end
      DECODE: begin
        if (mdu_cls && MDUBusy) begin
          nxt = DECODE;
        end else if (d.j) begin
          PCWE = 1'b1; NPCOp = 3'd2; nxt = FETCH;
        end else if (d.jr) begin
          PCWE = 1'b1; NPCOp = 3'd4; nxt = FETCH;
        end else if (d.jal) begin
          PCWE = 1'b1; NPCOp = 3'd3; nxt = WB;
        end else if (legal) begin
          nxt = EXEC;
        end else begin
          nxt = FETCH;
        end
      end
      EXEC: begin
        nxt = FETCH;
        if (alu_r) begin
          ALUOp = d.sub ? 4'd1 : (d.slt ? 4'd3 : 4'd0);
          nxt   = WB;
        end else if (d.ori || d.lui) begin
          ALUOp = d.ori ? 4'd2 : 4'd6;
          BSel  = 1'b1;
          nxt   = WB;
        end else if (d.lw || d.sw) begin
          ALUOp    = d.lw ? 4'd4 : 4'd5;
          BSel     = 1'b1;
          immExtOp = 1'b1;
          nxt      = MEM;
        end else if (d.beq) begin
          ALUOp = 4'd1;
          NPCOp = 3'd1;
          PCWE  = zero;
        end else if (mdu_go) begin
          MDUStart = 1'b1;
          MDUOp    = d.mult ? 3'd1 : d.multu ? 3'd2 : d.div ? 3'd3 : 3'd4;
        end else if (mdu_mt) begin
          HILOWE = 1'b1;
          MDUOp  = d.mthi ? 3'd5 : 3'd6;
        end else if (mdu_mf) begin
          nxt = WB;
        end
      end
      MEM: begin
        nxt  = d.lw ? WB : FETCH;
        DMWE = d.sw;
      end
      WB: begin
        RFWE = 1'b1;
        nxt  = FETCH;
        if (d.lw) begin
          RFWDSel = 2'd1;
        end else if (d.jal) begin
          WRSel = 2'd2; RFWDSel = 2'd2;
        end else if (mdu_mf) begin
          WRSel = 2'd1; RFWDSel = 2'd3; HILOSel = d.mfhi;
        end else if (alu_r) begin
          WRSel = 2'd1;
        end
      end
      default: nxt = FETCH;
    endcase
    // Reset masks every side effect so an aborted instruction commits nothing.
    if (reset) begin
      PCWE     = 1'b0;
      IRWE     = 1'b0;
      RFWE     = 1'b0;
      DMWE     = 1'b0;
      MDUStart = 1'b0;
      HILOWE   = 1'b0;
    end
  end

endmodule
